// File: rtl/prod_accumulator_if.sv
// Handshake bundle between the product source, the frame accumulator and its consumer.
interface prod_accumulator_if #(
    parameter int ACC_W = 10
);
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       prd;
    logic             clr;
    logic [ACC_W-1:0] acc_out;
    logic             out_valid;
    logic             out_ready;
    logic             ovf;

    modport master (
        output in_valid, prd, clr, out_ready,
        input  in_ready, acc_out, out_valid, ovf
    );

    modport slave (
        input  in_valid, prd, clr, out_ready,
        output in_ready, acc_out, out_valid, ovf
    );
endinterface

// File: rtl/prod_accumulator.sv
// Sums LEN unsigned 8-bit products per frame with saturation, then holds the
// result until the consumer takes it; clr aborts the frame in either state.
module prod_accumulator #(
    parameter int LEN   = 4,
    parameter int ACC_W = 10
) (
    input logic               clk,
    input logic               rst_n,
    prod_accumulator_if.slave bus
);
    localparam int CNT_W = (LEN > 1) ? $clog2(LEN) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(LEN - 1);

    typedef enum logic {ACCUM, HOLD} state_t;

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             take;
    logic [ACC_W:0]   sum;

    // rst_n gates in_ready so nothing is offered while reset is held.
    assign bus.in_ready  = rst_n && (state_q == ACCUM) && !bus.clr;
    assign take          = bus.in_valid && bus.in_ready;
    assign sum           = {1'b0, acc_q} + {{(ACC_W - 7){1'b0}}, bus.prd};

    assign bus.out_valid = (state_q == HOLD);
    assign bus.acc_out   = (state_q == HOLD) ? acc_q : '0;
    assign bus.ovf       = (state_q == HOLD) && ovf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ACCUM;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        if (bus.clr) begin
            state_d = ACCUM;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (take) begin
                        // Carry out of the wide add means saturate; ovf stays sticky.
                        if (sum[ACC_W]) begin
                            acc_d = '1;
                            ovf_d = 1'b1;
                        end else begin
                            acc_d = sum[ACC_W-1:0];
                        end
                        if (cnt_q == LAST) begin
                            cnt_d   = '0;
                            state_d = HOLD;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        state_d = ACCUM;
                        acc_d   = '0;
                        ovf_d   = 1'b0;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_prod_accumulator.sv
// Bench for prod_accumulator: four parameterisations driven by directed and
// randomized frames, checked against a queue-based frame model.
module tb_prod_accumulator;
    logic clk = 1'b0;
    logic rst_n;
    logic [3:0] iv, clr_a, ordy;
    logic [7:0] prd_a [4];
    logic [3:0] irdy, ov, of;
    logic [15:0] acc_a [4];

    int lens [4] = '{4, 2, 3, 1};
    int maxv [4] = '{1023, 255, 1023, 1023};
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    prod_accumulator_if #(.ACC_W(10)) b0 ();
    prod_accumulator_if #(.ACC_W(8))  b1 ();
    prod_accumulator_if #(.ACC_W(10)) b2 ();
    prod_accumulator_if #(.ACC_W(10)) b3 ();

    prod_accumulator #(.LEN(4), .ACC_W(10)) u0 (.clk(clk), .rst_n(rst_n), .bus(b0));
    prod_accumulator #(.LEN(2), .ACC_W(8))  u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
    prod_accumulator #(.LEN(3), .ACC_W(10)) u2 (.clk(clk), .rst_n(rst_n), .bus(b2));
    prod_accumulator #(.LEN(1), .ACC_W(10)) u3 (.clk(clk), .rst_n(rst_n), .bus(b3));

    assign b0.in_valid = iv[0];   assign b0.prd = prd_a[0];
    assign b0.clr = clr_a[0];     assign b0.out_ready = ordy[0];
    assign b1.in_valid = iv[1];   assign b1.prd = prd_a[1];
    assign b1.clr = clr_a[1];     assign b1.out_ready = ordy[1];
    assign b2.in_valid = iv[2];   assign b2.prd = prd_a[2];
    assign b2.clr = clr_a[2];     assign b2.out_ready = ordy[2];
    assign b3.in_valid = iv[3];   assign b3.prd = prd_a[3];
    assign b3.clr = clr_a[3];     assign b3.out_ready = ordy[3];

    assign irdy = {b3.in_ready, b2.in_ready, b1.in_ready, b0.in_ready};
    assign ov   = {b3.out_valid, b2.out_valid, b1.out_valid, b0.out_valid};
    assign of   = {b3.ovf, b2.ovf, b1.ovf, b0.ovf};
    assign acc_a[0] = {6'd0, b0.acc_out};
    assign acc_a[1] = {8'd0, b1.acc_out};
    assign acc_a[2] = {6'd0, b2.acc_out};
    assign acc_a[3] = {6'd0, b3.acc_out};

    // Offers one product and waits (bounded) for it to be accepted.
    task automatic push(input int k, input logic [7:0] p);
        int t = 0;
        iv[k] = 1'b1;
        prd_a[k] = p;
        @(negedge clk);
        while (!irdy[k] && t < 20) begin
            @(negedge clk);
            t++;
        end
        n_cmp++;
        if (!irdy[k]) begin
            $display("FAIL push_timeout k=%0d in_ready got=%0b exp=1", k, irdy[k]);
            n_bad++;
        end
        @(posedge clk); #1;
        iv[k] = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            n_cmp += 4;
            if (irdy[k] !== 1'b0) begin $display("FAIL rst_in_ready k=%0d got=%0b exp=0", k, irdy[k]); n_bad++; end
            if (ov[k] !== 1'b0) begin $display("FAIL rst_out_valid k=%0d got=%0b exp=0", k, ov[k]); n_bad++; end
            if (acc_a[k] !== 16'd0) begin $display("FAIL rst_acc_out k=%0d got=%0d exp=0", k, acc_a[k]); n_bad++; end
            if (of[k] !== 1'b0) begin $display("FAIL rst_ovf k=%0d got=%0b exp=0", k, of[k]); n_bad++; end
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (irdy[k] !== 1'b1) begin $display("FAIL rst_release_ready k=%0d got=%0b exp=1", k, irdy[k]); n_bad++; end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        logic [7:0] p [4] = '{8'd15, 8'd30, 8'd45, 8'd225};
        ordy[0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push(0, p[i]);
            n_cmp++;
            if (ov[0] !== (i == 3)) begin $display("FAIL basic_valid_timing i=%0d got=%0b exp=%0b", i, ov[0], (i == 3)); n_bad++; end
        end
        @(negedge clk);
        n_cmp += 2;
        if (acc_a[0] !== 16'd315) begin $display("FAIL basic_sum got=%0d exp=315", acc_a[0]); n_bad++; end
        if (of[0] !== 1'b0) begin $display("FAIL basic_ovf got=%0b exp=0", of[0]); n_bad++; end
        @(posedge clk); #1;
        @(negedge clk);
        n_cmp++;
        if (ov[0] !== 1'b0) begin $display("FAIL basic_valid_drop got=%0b exp=0", ov[0]); n_bad++; end
        @(posedge clk); #1;
    endtask

    task automatic test_saturation();
        ordy[1] = 1'b1;
        push(1, 8'd225);
        push(1, 8'd225);
        @(negedge clk);
        n_cmp += 3;
        if (ov[1] !== 1'b1) begin $display("FAIL sat_valid got=%0b exp=1", ov[1]); n_bad++; end
        if (acc_a[1] !== 16'd255) begin $display("FAIL sat_sum got=%0d exp=255", acc_a[1]); n_bad++; end
        if (of[1] !== 1'b1) begin $display("FAIL sat_ovf got=%0b exp=1", of[1]); n_bad++; end
        @(posedge clk); #1;
        push(1, 8'd1);
        push(1, 8'd2);
        @(negedge clk);
        n_cmp += 2;
        if (acc_a[1] !== 16'd3) begin $display("FAIL sat_next_sum got=%0d exp=3", acc_a[1]); n_bad++; end
        if (of[1] !== 1'b0) begin $display("FAIL sat_next_ovf got=%0b exp=0", of[1]); n_bad++; end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        int s = 0;
        int v;
        ordy[0] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            v = $urandom_range(0, 200);
            s += v;
            push(0, 8'(v));
        end
        iv[0] = 1'b1;
        prd_a[0] = 8'd77;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_cmp += 4;
            if (ov[0] !== 1'b1) begin $display("FAIL bp_valid c=%0d got=%0b exp=1", c, ov[0]); n_bad++; end
            if (acc_a[0] !== 16'(s)) begin $display("FAIL bp_sum c=%0d got=%0d exp=%0d", c, acc_a[0], s); n_bad++; end
            if (of[0] !== 1'b0) begin $display("FAIL bp_ovf c=%0d got=%0b exp=0", c, of[0]); n_bad++; end
            if (irdy[0] !== 1'b0) begin $display("FAIL bp_in_ready c=%0d got=%0b exp=0", c, irdy[0]); n_bad++; end
            @(posedge clk); #1;
        end
        ordy[0] = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        n_cmp += 2;
        if (ov[0] !== 1'b0) begin $display("FAIL bp_release_valid got=%0b exp=0", ov[0]); n_bad++; end
        if (irdy[0] !== 1'b1) begin $display("FAIL bp_bubble_ready got=%0b exp=1", irdy[0]); n_bad++; end
        @(posedge clk); #1;
        iv[0] = 1'b0;
        push(0, 8'd1);
        push(0, 8'd2);
        push(0, 8'd3);
        @(negedge clk);
        n_cmp++;
        if (acc_a[0] !== 16'd83) begin $display("FAIL bp_held_first_sum got=%0d exp=83", acc_a[0]); n_bad++; end
        @(posedge clk); #1;
    endtask

    task automatic test_abort();
        ordy[0] = 1'b1;
        push(0, 8'd100);
        push(0, 8'd100);
        clr_a[0] = 1'b1;
        iv[0] = 1'b1;
        prd_a[0] = 8'd50;
        @(negedge clk);
        n_cmp++;
        if (irdy[0] !== 1'b0) begin $display("FAIL abort_ready got=%0b exp=0", irdy[0]); n_bad++; end
        @(posedge clk); #1;
        clr_a[0] = 1'b0;
        iv[0] = 1'b0;
        repeat (4) push(0, 8'd10);
        @(negedge clk);
        n_cmp += 2;
        if (acc_a[0] !== 16'd40) begin $display("FAIL abort_sum got=%0d exp=40", acc_a[0]); n_bad++; end
        if (of[0] !== 1'b0) begin $display("FAIL abort_ovf got=%0b exp=0", of[0]); n_bad++; end
        // clr also discards a held result
        ordy[0] = 1'b0;
        @(posedge clk); #1;
        clr_a[0] = 1'b1;
        @(posedge clk); #1;
        clr_a[0] = 1'b0;
        ordy[0] = 1'b1;
        @(negedge clk);
        n_cmp += 2;
        if (ov[0] !== 1'b0) begin $display("FAIL abort_hold_valid got=%0b exp=0", ov[0]); n_bad++; end
        if (acc_a[0] !== 16'd0) begin $display("FAIL abort_hold_acc got=%0d exp=0", acc_a[0]); n_bad++; end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        ordy[0] = 1'b1;
        push(0, 8'd225);
        push(0, 8'd225);
        rst_n = 1'b0;
        #1;
        n_cmp += 3;
        if (irdy[0] !== 1'b0) begin $display("FAIL rmid_ready got=%0b exp=0", irdy[0]); n_bad++; end
        if (ov[0] !== 1'b0) begin $display("FAIL rmid_valid got=%0b exp=0", ov[0]); n_bad++; end
        if (acc_a[0] !== 16'd0) begin $display("FAIL rmid_acc got=%0d exp=0", acc_a[0]); n_bad++; end
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (4) push(0, 8'd225);
        @(negedge clk);
        n_cmp += 3;
        if (ov[0] !== 1'b1) begin $display("FAIL rmid_frame_valid got=%0b exp=1", ov[0]); n_bad++; end
        if (acc_a[0] !== 16'd900) begin $display("FAIL rmid_sum got=%0d exp=900", acc_a[0]); n_bad++; end
        if (of[0] !== 1'b0) begin $display("FAIL rmid_ovf got=%0b exp=0", of[0]); n_bad++; end
        @(posedge clk); #1;
    endtask

    task automatic test_stall();
        ordy[2] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            push(2, 8'd8);
            if (i < 2) begin
                @(negedge clk);
                n_cmp++;
                if (ov[2] !== 1'b0) begin $display("FAIL stall_early_valid i=%0d got=%0b exp=0", i, ov[2]); n_bad++; end
                @(posedge clk); #1;
            end
        end
        @(negedge clk);
        n_cmp += 2;
        if (ov[2] !== 1'b1) begin $display("FAIL stall_valid got=%0b exp=1", ov[2]); n_bad++; end
        if (acc_a[2] !== 16'd24) begin $display("FAIL stall_sum got=%0d exp=24", acc_a[2]); n_bad++; end
        @(posedge clk); #1;
    endtask

    task automatic test_zero();
        ordy[0] = 1'b1;
        push(0, 8'd0);
        push(0, 8'd0);
        push(0, 8'd0);
        push(0, 8'd5);
        @(negedge clk);
        n_cmp += 2;
        if (ov[0] !== 1'b1) begin $display("FAIL zero_count_valid got=%0b exp=1", ov[0]); n_bad++; end
        if (acc_a[0] !== 16'd5) begin $display("FAIL zero_sum got=%0d exp=5", acc_a[0]); n_bad++; end
        @(posedge clk); #1;
    endtask

    // Frame-level reference: a queue of accepted products per frame.
    task automatic test_random(input int k, input int cycles);
        int q[$];
        bit hold = 1'b0;
        int hsum = 0;
        bit hovf = 1'b0;
        int tot;
        clr_a[k] = 1'b1;
        iv[k] = 1'b0;
        @(posedge clk); #1;
        clr_a[k] = 1'b0;
        repeat (cycles) begin
            iv[k]    = ($urandom_range(0, 9) < 7);
            prd_a[k] = 8'($urandom_range(0, 255));
            clr_a[k] = ($urandom_range(0, 19) == 0);
            ordy[k]  = 1'($urandom_range(0, 1));
            @(negedge clk);
            n_cmp += 4;
            if (irdy[k] !== (!hold && !clr_a[k])) begin $display("FAIL rnd_in_ready k=%0d got=%0b exp=%0b", k, irdy[k], (!hold && !clr_a[k])); n_bad++; end
            if (ov[k] !== hold) begin $display("FAIL rnd_out_valid k=%0d got=%0b exp=%0b", k, ov[k], hold); n_bad++; end
            if (acc_a[k] !== 16'(hold ? hsum : 0)) begin $display("FAIL rnd_acc_out k=%0d got=%0d exp=%0d", k, acc_a[k], (hold ? hsum : 0)); n_bad++; end
            if (of[k] !== (hold && hovf)) begin $display("FAIL rnd_ovf k=%0d got=%0b exp=%0b", k, of[k], (hold && hovf)); n_bad++; end
            if (clr_a[k]) begin
                hold = 1'b0;
                q.delete();
            end else if (hold) begin
                if (ordy[k]) hold = 1'b0;
            end else if (iv[k]) begin
                q.push_back(int'(prd_a[k]));
                if (q.size() == lens[k]) begin
                    tot  = q.sum();
                    hsum = (tot > maxv[k]) ? maxv[k] : tot;
                    hovf = (tot > maxv[k]);
                    hold = 1'b1;
                    q.delete();
                end
            end
            @(posedge clk); #1;
        end
        clr_a[k] = 1'b0;
        iv[k] = 1'b0;
        ordy[k] = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        iv = '0;
        clr_a = '0;
        ordy = '1;
        for (int k = 0; k < 4; k++) prd_a[k] = '0;
        test_reset();
        test_basic();
        test_saturation();
        test_backpressure();
        test_abort();
        test_reset_mid();
        test_stall();
        test_zero();
        test_random(0, 400);
        test_random(1, 400);
        test_random(3, 300);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached compared=%0d", n_cmp);
        $fatal(1, "watchdog");
    end
endmodule
